// File: rtl/spgd_seq_fsm.sv
// SPGD iteration sequencer: +perturb, settle, integrate J+, -perturb, settle, integrate J-,
// update and restore nominal across N_CH DAC channels, with run modes, abort and iteration count.
module spgd_seq_fsm #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
) (
    input  logic             adc_clk,
    input  logic             adc_rstn,
    input  logic             start,
    input  logic             TRIG_IN,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] settle_cycles,
    input  logic [CNT_W-1:0] integ_cycles,
    output logic [1:0]       FSM_DAC_SEL,
    output logic [CH_W-1:0]  FSM_CH,
    output logic             FSM_DAC_WR,
    output logic             FSM_INT_EN,
    output logic             FSM_JP_WRT,
    output logic             FSM_JM_WRT,
    output logic             FSM_U_WRT,
    output logic             FSM_DONE,
    output logic             FSM_BUSY,
    output logic [5:0]       FSM_STATE,
    output logic [31:0]      iter_count
);

    typedef enum logic [5:0] {
        ST_IDLE     = 6'd0,
        ST_ARM      = 6'd1,
        ST_SET_P    = 6'd2,
        ST_SETTLE_P = 6'd3,
        ST_INTEG_P  = 6'd4,
        ST_LATCH_P  = 6'd5,
        ST_SET_M    = 6'd6,
        ST_SETTLE_M = 6'd7,
        ST_INTEG_M  = 6'd8,
        ST_LATCH_M  = 6'd9,
        ST_UPDATE   = 6'd10,
        ST_SET_U    = 6'd11,
        ST_DONE     = 6'd12
    } state_t;

    localparam logic [CH_W-1:0]  CH_ZERO  = {CH_W{1'b0}};
    localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           raw_state_s;
    state_t           next_state_s;
    logic [CH_W-1:0]  ch_r;
    logic [CH_W-1:0]  raw_ch_s;
    logic [CH_W-1:0]  next_ch_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] raw_cnt_s;
    logic [CNT_W-1:0] next_cnt_s;
    logic             raw_latch_s;
    logic             latch_cfg_s;
    logic [CNT_W-1:0] settle_r;
    logic [CNT_W-1:0] integ_r;

    logic             trig_s1_r;
    logic             trig_s2_r;
    logic             trig_s3_r;
    logic             trig_edge_s;

    logic             ch_last_s;
    logic             settle_zero_s;
    logic             settle_end_s;
    logic             integ_end_s;
    logic             stop_after_s;

    logic [1:0]       dac_sel_s;
    logic             dac_wr_s;
    logic             int_en_s;
    logic             jp_s;
    logic             jm_s;
    logic             u_s;
    logic             done_s;
    logic             busy_s;

    logic [1:0]       dac_sel_r;
    logic             dac_wr_r;
    logic             int_en_r;
    logic             jp_r;
    logic             jm_r;
    logic             u_r;
    logic             done_r;
    logic             busy_r;
    logic [31:0]      iter_r;

    assign trig_edge_s   = trig_s2_r & ~trig_s3_r;
    assign ch_last_s     = (ch_r == CH_LAST);
    assign settle_zero_s = (settle_r == CNT_ZERO);
    assign settle_end_s  = (cnt_r == (settle_r - CNT_ONE));
    // A zero integration window still integrates for one cycle.
    assign integ_end_s   = (integ_r == CNT_ZERO) || (cnt_r == (integ_r - CNT_ONE));
    assign stop_after_s  = ~start || (mode == 2'd0) || (mode == 2'd3);

    // Two-flop synchroniser plus a history flop for rising-edge detection of TRIG_IN.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            trig_s1_r <= 1'b0;
            trig_s2_r <= 1'b0;
            trig_s3_r <= 1'b0;
        end else begin
            trig_s1_r <= TRIG_IN;
            trig_s2_r <= trig_s1_r;
            trig_s3_r <= trig_s2_r;
        end
    end

    // Phase sequencing ignoring abort: next state, channel index, window counter, config latch.
    always_comb begin
        raw_state_s = state_r;
        raw_ch_s    = CH_ZERO;
        raw_cnt_s   = CNT_ZERO;
        raw_latch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!start) begin
                    raw_state_s = ST_IDLE;
                end else if (mode == 2'd2) begin
                    raw_state_s = ST_SET_P;
                    raw_latch_s = 1'b1;
                end else begin
                    raw_state_s = ST_ARM;
                end
            end
            ST_ARM: begin
                if (trig_edge_s) begin
                    raw_state_s = ST_SET_P;
                    raw_latch_s = 1'b1;
                end else if (!start) begin
                    raw_state_s = ST_IDLE;
                end else begin
                    raw_state_s = ST_ARM;
                end
            end
            ST_SET_P: begin
                if (ch_last_s) begin
                    raw_state_s = settle_zero_s ? ST_INTEG_P : ST_SETTLE_P;
                end else begin
                    raw_ch_s = ch_r + CH_ONE;
                end
            end
            ST_SETTLE_P: begin
                if (settle_end_s) begin
                    raw_state_s = ST_INTEG_P;
                end else begin
                    raw_cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_INTEG_P: begin
                if (integ_end_s) begin
                    raw_state_s = ST_LATCH_P;
                end else begin
                    raw_cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_LATCH_P: raw_state_s = ST_SET_M;
            ST_SET_M: begin
                if (ch_last_s) begin
                    raw_state_s = settle_zero_s ? ST_INTEG_M : ST_SETTLE_M;
                end else begin
                    raw_ch_s = ch_r + CH_ONE;
                end
            end
            ST_SETTLE_M: begin
                if (settle_end_s) begin
                    raw_state_s = ST_INTEG_M;
                end else begin
                    raw_cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_INTEG_M: begin
                if (integ_end_s) begin
                    raw_state_s = ST_LATCH_M;
                end else begin
                    raw_cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_LATCH_M: raw_state_s = ST_UPDATE;
            ST_UPDATE:  raw_state_s = ST_SET_U;
            ST_SET_U: begin
                if (ch_last_s) begin
                    raw_state_s = ST_DONE;
                end else begin
                    raw_ch_s = ch_r + CH_ONE;
                end
            end
            ST_DONE: begin
                if (stop_after_s) begin
                    raw_state_s = ST_IDLE;
                end else if (mode == 2'd1) begin
                    raw_state_s = ST_ARM;
                end else begin
                    raw_state_s = ST_SET_P;
                    raw_latch_s = 1'b1;
                end
            end
            default: raw_state_s = ST_IDLE;
        endcase
    end

    // Abort overrides every transition and returns to IDLE with counters cleared.
    always_comb begin
        if (abort) begin
            next_state_s = ST_IDLE;
            next_ch_s    = CH_ZERO;
            next_cnt_s   = CNT_ZERO;
            latch_cfg_s  = 1'b0;
        end else begin
            next_state_s = raw_state_s;
            next_ch_s    = raw_ch_s;
            next_cnt_s   = raw_cnt_s;
            latch_cfg_s  = raw_latch_s;
        end
    end

    // Output decode from the next state so every strobe is registered alongside the state.
    always_comb begin
        dac_sel_s = 2'd0;
        dac_wr_s  = 1'b0;
        int_en_s  = 1'b0;
        jp_s      = 1'b0;
        jm_s      = 1'b0;
        u_s       = 1'b0;
        done_s    = 1'b0;
        busy_s    = (next_state_s != ST_IDLE) && (next_state_s != ST_ARM);
        case (next_state_s)
            ST_SET_P: begin
                dac_sel_s = 2'd1;
                dac_wr_s  = 1'b1;
            end
            ST_SET_M: begin
                dac_sel_s = 2'd2;
                dac_wr_s  = 1'b1;
            end
            ST_SET_U:   dac_wr_s = 1'b1;
            ST_INTEG_P: int_en_s = 1'b1;
            ST_INTEG_M: int_en_s = 1'b1;
            ST_LATCH_P: jp_s     = 1'b1;
            ST_LATCH_M: jm_s     = 1'b1;
            ST_UPDATE:  u_s      = 1'b1;
            ST_DONE:    done_s   = 1'b1;
            default:    dac_wr_s = 1'b0;
        endcase
    end

    // State, channel index, window counter and per-iteration config snapshot.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            state_r  <= ST_IDLE;
            ch_r     <= CH_ZERO;
            cnt_r    <= CNT_ZERO;
            settle_r <= CNT_ZERO;
            integ_r  <= CNT_ZERO;
        end else begin
            state_r <= next_state_s;
            ch_r    <= next_ch_s;
            cnt_r   <= next_cnt_s;
            if (latch_cfg_s) begin
                settle_r <= settle_cycles;
                integ_r  <= integ_cycles;
            end
        end
    end

    // Registered strobes and the completed-iteration counter (advances as DONE is entered).
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            dac_sel_r <= 2'd0;
            dac_wr_r  <= 1'b0;
            int_en_r  <= 1'b0;
            jp_r      <= 1'b0;
            jm_r      <= 1'b0;
            u_r       <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            iter_r    <= 32'd0;
        end else begin
            dac_sel_r <= dac_sel_s;
            dac_wr_r  <= dac_wr_s;
            int_en_r  <= int_en_s;
            jp_r      <= jp_s;
            jm_r      <= jm_s;
            u_r       <= u_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
            if (done_s) begin
                iter_r <= iter_r + 32'd1;
            end
        end
    end

    assign FSM_STATE   = state_r;
    assign FSM_CH      = ch_r;
    assign FSM_DAC_SEL = dac_sel_r;
    assign FSM_DAC_WR  = dac_wr_r;
    assign FSM_INT_EN  = int_en_r;
    assign FSM_JP_WRT  = jp_r;
    assign FSM_JM_WRT  = jm_r;
    assign FSM_U_WRT   = u_r;
    assign FSM_DONE    = done_r;
    assign FSM_BUSY    = busy_r;
    assign iter_count  = iter_r;

endmodule

// File: doc/spgd_seq_fsm.md
Name: spgd_seq_fsm

Overview:
- Parametrised successor to the single-channel SPGD sequencer.
- Runs one full SPGD iteration: +perturb, settle, integrate J+, −perturb, settle, integrate J−, update, restore nominal, across N_CH DAC channels.
- Adds programmable settle and integration windows, three run modes, abort, and an iteration counter.
- Sits between trigger/ADC front end and the JP/JM/U register banks and DAC mux.

Parameters:
- N_CH, 4, number of DAC channels written per SET phase (1..64)
- CNT_W, 16, width of settle/integration counters and config inputs
- CH_W, 2, width of channel index; must be ≥ max(1, clog2(N_CH))

Ports:
adc_clk  in  1  system clock, all logic on rising edge
adc_rstn  in  1  asynchronous active-low reset
start  in  1  level enable; 1 = run permitted
TRIG_IN  in  1  asynchronous external trigger, rising edge starts iteration
abort  in  1  synchronous abort, level
mode  in  2  0 single-shot, 1 triggered-continuous, 2 free-run, 3 = treated as 0
settle_cycles  in  CNT_W  settle wait after each SET phase
integ_cycles  in  CNT_W  integration window length
FSM_DAC_SEL  out  2  0 nominal U, 1 U+δ, 2 U−δ (3 never driven)
FSM_CH  out  CH_W  channel index being written
FSM_DAC_WR  out  1  DAC write strobe, one per channel
FSM_INT_EN  out  1  integrator enable
FSM_JP_WRT  out  1  one-cycle latch J+
FSM_JM_WRT  out  1  one-cycle latch J−
FSM_U_WRT  out  1  one-cycle U update
FSM_DONE  out  1  one-cycle iteration complete
FSM_BUSY  out  1  high in every state except IDLE and ARM
FSM_STATE  out  6  current state code
iter_count  out  32  completed iterations, wraps 0xFFFFFFFF→0

Behaviour:
- Reset (adc_rstn=0, async):
  - state IDLE; all strobes 0; FSM_DAC_SEL=0; FSM_CH=0; iter_count=0; trigger synchroniser cleared.
- TRIG_IN path:
  - 2-flop synchroniser, then rising-edge detect.
  - Edge sampled into ARM 3 cycles after the TRIG_IN rise.
  - Edges outside ARM are ignored, not queued.
- State codes:
  IDLE=0, ARM=1, SET_P=2, SETTLE_P=3, INTEG_P=4, LATCH_P=5, SET_M=6, SETTLE_M=7, INTEG_M=8, LATCH_M=9, UPDATE=10, SET_U=11, DONE=12.
- IDLE:
  - start=1 → ARM, except mode=2 → SET_P directly.
- ARM:
  - synced trigger edge → SET_P.
  - start=0 → IDLE.
- SET_P / SET_M / SET_U:
  - FSM_DAC_SEL = 1 / 2 / 0 respectively, held throughout the phase.
  - FSM_DAC_WR=1 for exactly N_CH cycles with FSM_CH = 0..N_CH-1, then FSM_CH returns to 0.
- Config latch:
  - settle_cycles and integ_cycles are latched on entry to SET_P.
  - Input changes mid-iteration have no effect until the next iteration.
- SETTLE_x:
  - Waits latched settle count cycles.
  - Count 0 → state occupies 0 cycles: SET_x goes directly to INTEG_x.
- INTEG_x:
  - FSM_INT_EN=1 for latched integ count cycles; 0 is treated as 1.
- LATCH_P / LATCH_M:
  - single cycle; FSM_JP_WRT / FSM_JM_WRT =1.
- UPDATE:
  - single cycle; FSM_U_WRT=1, FSM_DAC_SEL=0.
- DONE:
  - single cycle; FSM_DONE=1; iter_count increments in the same cycle.
  - Next state:
    - start=0 → IDLE
    - mode=0 or 3 → IDLE
    - mode=1 → ARM
    - mode=2 → SET_P
- start deassert mid-iteration: the current iteration completes, then IDLE.
- abort=1 in any state:
  - next cycle IDLE; all strobes forced 0 that same next cycle.
  - iter_count unchanged.
  - abort has priority over every other transition.
- Iteration length, N=N_CH, S=settle, I=max(integ,1): 3N + 2S + 2I + 4 cycles from SET_P entry through DONE.
- Strobes are registered outputs, glitch-free, and never overlap except DAC_WR with FSM_CH.

Test Plan:
- Reset: assert adc_rstn=0 mid-INTEG_P → FSM_STATE=0, all strobes 0, iter_count=0 immediately, without waiting for a clock edge.
- Single-shot, N_CH=4, settle=2, integ=5, mode=0, start=1, one TRIG_IN pulse:
  - SET_P entered 3 cycles after the TRIG_IN rise; FSM_DONE 30 cycles after SET_P entry.
  - Exactly 12 DAC_WR pulses; JP, JM, U each pulse once; returns to IDLE; iter_count=1.
- Edge counts settle=0, integ=0 → iteration 18 cycles, FSM_INT_EN high exactly 1 cycle per integrate phase.
- Free-run mode=2 for 5 iterations, then start=0 during SETTLE_M → iteration completes, iter_count=6, then IDLE.
- Triggered-continuous mode=1 with TRIG_IN pulsed during INTEG_P → pulse ignored; after DONE the FSM waits in ARM until the next pulse.
- abort=1 for one cycle during SET_M at FSM_CH=2 → next cycle IDLE, DAC_WR=0, no JM/U pulse, iter_count unchanged.
